// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register file writeback arbiter.
// Holds register file geometry and the write bundle type.
package rf_pkg;

   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int REG_AW = 5;

   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } rf_wr_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between requesters, issue logic and the arbiter.
// slave: arbiter side; master: requesters, issue logic and rf sink.
interface rf_wb_if;
   import rf_pkg::*;

   logic              req0_valid;
   logic              req0_ready;
   logic [REG_AW-1:0] req0_rd;
   logic [XLEN-1:0]   req0_data;

   logic              req1_valid;
   logic              req1_ready;
   logic [REG_AW-1:0] req1_rd;
   logic [XLEN-1:0]   req1_data;

   logic              rf_we;
   logic [REG_AW-1:0] rf_rd;
   logic [XLEN-1:0]   rf_wdata;

   logic              sb_set;
   logic [REG_AW-1:0] sb_set_rd;
   logic [REG_AW-1:0] sb_rs1;
   logic [REG_AW-1:0] sb_rs2;
   logic              sb_rs1_busy;
   logic              sb_rs2_busy;

   logic              unexp_wb;

   modport slave (
      input  req0_valid, req0_rd, req0_data,
      input  req1_valid, req1_rd, req1_data,
      input  sb_set, sb_set_rd, sb_rs1, sb_rs2,
      output req0_ready, req1_ready,
      output rf_we, rf_rd, rf_wdata,
      output sb_rs1_busy, sb_rs2_busy,
      output unexp_wb
   );

   modport master (
      output req0_valid, req0_rd, req0_data,
      output req1_valid, req1_rd, req1_data,
      output sb_set, sb_set_rd, sb_rs1, sb_rs2,
      input  req0_ready, req1_ready,
      input  rf_we, rf_rd, rf_wdata,
      input  sb_rs1_busy, sb_rs2_busy,
      input  unexp_wb
   );

endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Per-register pending-write scoreboard with two hazard query ports.
// Ports: set/set_rd mark busy, clr/clr_rd retire, rs1/rs2 query, clr_busy.
module rf_scoreboard
   import rf_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              set,
   input  logic [REG_AW-1:0] set_rd,
   input  logic              clr,
   input  logic [REG_AW-1:0] clr_rd,
   input  logic              rf_we,
   input  logic [REG_AW-1:0] rf_rd,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic              clr_busy
);

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;

   // Set is applied after clear: a new producer wins a same-cycle retire.
   always_comb begin
      busy_nxt = busy;
      if (clr)
         busy_nxt[clr_rd] = 1'b0;
      if (set)
         busy_nxt[set_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

   // The rf_we term covers the cycle after retire, before the
   // register file write has landed.
   assign rs1_busy = busy[rs1]
                   | (rf_we && rf_rd == rs1 && rs1 != REG_ZERO);
   assign rs2_busy = busy[rs2]
                   | (rf_we && rf_rd == rs2 && rs2 != REG_ZERO);

   assign clr_busy = busy[clr_rd];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register file write port arbiter: req0 priority, req1 aging override.
// Ports: clk, reset, bus (slave) carrying requests, rf write and scoreboard.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic    clk,
   input  logic    reset,
   rf_wb_if.slave  bus
);

   localparam int WCW = $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0] WMAX = WCW'(MAX_WAIT);

   logic [WCW-1:0] wait_cnt;
   logic           force1;
   logic           go0;
   logic           go1;
   logic           xfer;
   logic           win_live;
   logic           hit_busy;
   rf_wr_t         win;

   rf_wr_t         wb_q;
   logic           we_q;
   logic           unexp_q;

   always_comb begin
      force1 = bus.req1_valid && (wait_cnt == WMAX);
      go1    = !reset && bus.req1_valid
             && (!bus.req0_valid || force1);
      go0    = !reset && bus.req0_valid && !force1;
      xfer   = go0 || go1;
      if (go1)
         win = '{rd: bus.req1_rd, data: bus.req1_data};
      else
         win = '{rd: bus.req0_rd, data: bus.req0_data};
      // x0 writes are consumed but never reach the register file.
      win_live = xfer && (win.rd != REG_ZERO);
   end

   assign bus.req0_ready = go0;
   assign bus.req1_ready = go1;

   // Counts consecutive refusals of a valid req1.
   always_ff @(posedge clk) begin
      if (reset)
         wait_cnt <= '0;
      else if (!bus.req1_valid || go1)
         wait_cnt <= '0;
      else if (wait_cnt != WMAX)
         wait_cnt <= wait_cnt + WCW'(1);
   end

   // rf_rd/rf_wdata only move on a live write; otherwise they hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q    <= 1'b0;
         unexp_q <= 1'b0;
         wb_q    <= '0;
      end else begin
         we_q    <= win_live;
         unexp_q <= win_live && !hit_busy;
         if (win_live)
            wb_q <= win;
      end
   end

   assign bus.rf_we    = we_q;
   assign bus.rf_rd    = wb_q.rd;
   assign bus.rf_wdata = wb_q.data;
   assign bus.unexp_wb = unexp_q;

   rf_scoreboard u_sb (
      .clk      (clk),
      .reset    (reset),
      .set      (bus.sb_set),
      .set_rd   (bus.sb_set_rd),
      .clr      (xfer),
      .clr_rd   (win.rd),
      .rf_we    (we_q),
      .rf_rd    (wb_q.rd),
      .rs1      (bus.sb_rs1),
      .rs2      (bus.sb_rs2),
      .rs1_busy (bus.sb_rs1_busy),
      .rs2_busy (bus.sb_rs2_busy),
      .clr_busy (hit_busy)
   );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed cases then random traffic.
// Expected writes are queued by the driver and checked by a monitor.
module tb_rf_wb_arbiter;
   import rf_pkg::*;

   localparam int MAX_WAIT = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   rf_wb_if bus ();

   rf_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   typedef struct {
      bit          we;
      bit          unexp;
      bit          full;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];

   // reference state
   bit          m_busy [32];
   int          m_refused;
   bit          m_we;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   bit          m_known = 0;
   bit          mon_on = 0;

   // staged stimulus
   bit          s_reset = 1;
   bit          s_v0 = 0, s_v1 = 0, s_set = 0;
   logic [4:0]  s_rd0 = 0, s_rd1 = 0, s_set_rd = 0;
   logic [4:0]  s_rs1 = 0, s_rs2 = 0;
   logic [31:0] s_d0 = 0, s_d1 = 0;
   bit          held0 = 0, held1 = 0;

   // DUT observations of the current step
   logic        act_r0, act_r1, act_b1, act_b2;

   task automatic step();
      bit          f1, e_r0, e_r1, eb1, eb2, x;
      logic [4:0]  wrd;
      logic [31:0] wd;
      exp_t        e;
      @(negedge clk);
      reset          = s_reset;
      bus.req0_valid = s_v0;
      bus.req0_rd    = s_rd0;
      bus.req0_data  = s_d0;
      bus.req1_valid = s_v1;
      bus.req1_rd    = s_rd1;
      bus.req1_data  = s_d1;
      bus.sb_set     = s_set;
      bus.sb_set_rd  = s_set_rd;
      bus.sb_rs1     = s_rs1;
      bus.sb_rs2     = s_rs2;
      #1;
      act_r0 = bus.req0_ready;
      act_r1 = bus.req1_ready;
      act_b1 = bus.sb_rs1_busy;
      act_b2 = bus.sb_rs2_busy;
      f1   = s_v1 && (m_refused >= MAX_WAIT);
      e_r1 = !s_reset && s_v1 && (!s_v0 || f1);
      e_r0 = !s_reset && s_v0 && !f1;
      chk("req0_ready", act_r0, e_r0);
      chk("req1_ready", act_r1, e_r1);
      if (m_known) begin
         eb1 = m_busy[s_rs1] || (m_we && m_rd == s_rs1 && s_rs1 != 0);
         eb2 = m_busy[s_rs2] || (m_we && m_rd == s_rs2 && s_rs2 != 0);
         chk("sb_rs1_busy", act_b1, eb1);
         chk("sb_rs2_busy", act_b2, eb2);
      end
      e.we = 0; e.unexp = 0; e.full = 0;
      if (s_reset) begin
         foreach (m_busy[i]) m_busy[i] = 0;
         m_refused = 0;
         m_we = 0; m_rd = 0; m_data = 0;
         e.full = 1;
         m_known = 1;
      end else begin
         x   = e_r0 || e_r1;
         wrd = e_r1 ? s_rd1 : s_rd0;
         wd  = e_r1 ? s_d1 : s_d0;
         e.we    = x && wrd != 0;
         e.unexp = e.we && !m_busy[wrd];
         if (e.we) begin
            m_rd = wrd;
            m_data = wd;
         end
         m_we = e.we;
         if (x) m_busy[wrd] = 0;
         if (s_set && s_set_rd != 0) m_busy[s_set_rd] = 1;
         m_refused = (s_v1 && !e_r1) ? m_refused + 1 : 0;
      end
      e.rd = m_rd;
      e.data = m_data;
      exp_q.push_back(e);
      mon_on = 1;
      held0 = s_v0 && !e_r0;
      held1 = s_v1 && !e_r1;
   endtask

   // monitor: one expected record per clock edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_on) begin
            if (exp_q.size() == 0) begin
               chk("queue_underflow", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("rf_we", bus.rf_we, e.we);
               chk("unexp_wb", bus.unexp_wb, e.unexp);
               if (e.we || e.full) begin
                  chk("rf_rd", bus.rf_rd, e.rd);
                  chk("rf_wdata", bus.rf_wdata, e.data);
               end
            end
         end
      end
   end

   task automatic idle();
      s_reset = 0; s_v0 = 0; s_v1 = 0; s_set = 0;
   endtask

   task automatic rnd();
      if (!held0) begin
         s_v0  = $urandom_range(0, 99) < 60;
         s_rd0 = 5'($urandom_range(0, 11));
         s_d0  = $urandom;
      end
      if (!held1) begin
         s_v1  = $urandom_range(0, 99) < 50;
         s_rd1 = 5'($urandom_range(0, 11));
         s_d1  = $urandom;
      end
      s_set    = $urandom_range(0, 3) == 0;
      s_set_rd = 5'($urandom_range(0, 11));
      s_rs1    = 5'($urandom_range(0, 11));
      s_rs2    = 5'($urandom_range(0, 11));
      s_reset  = $urandom_range(0, 199) == 0;
   endtask

   initial begin
      // reset
      s_reset = 1;
      step();
      step();
      idle();
      step();

      // contention: req1 forced on the 5th refused cycle
      s_v1 = 1; s_rd1 = 5'd2; s_d1 = 32'h1111_0000;
      for (int i = 0; i < 10; i++) begin
         s_v0 = 1; s_rd0 = 5'd1; s_d0 = 32'(i);
         step();
         chk($sformatf("cont_r1_%0d", i), act_r1, (i == 4 || i == 9));
         chk($sformatf("cont_r0_%0d", i), act_r0, !(i == 4 || i == 9));
         if (act_r1) s_d1 = s_d1 + 1;
      end
      idle();
      step();

      // latency
      s_v0 = 1; s_rd0 = 5'd5; s_d0 = 32'hDEAD_BEEF;
      step();
      idle();
      step();
      chk("lat_we", bus.rf_we, 1);
      chk("lat_rd", bus.rf_rd, 5);
      chk("lat_data", bus.rf_wdata, 32'hDEAD_BEEF);
      step();
      chk("lat_we_gone", bus.rf_we, 0);

      // x0 write
      s_v1 = 1; s_rd1 = 5'd0; s_d1 = 32'h0BAD_0BAD;
      step();
      chk("x0_ready", act_r1, 1);
      idle();
      step();
      chk("x0_we", bus.rf_we, 0);
      chk("x0_unexp", bus.unexp_wb, 0);

      // scoreboard on x7
      s_rs1 = 5'd7;
      s_set = 1; s_set_rd = 5'd7;
      step();
      s_set = 0;
      step();
      chk("sb7_set", act_b1, 1);
      s_v0 = 1; s_rd0 = 5'd7; s_d0 = 32'h7777;
      step();
      chk("sb7_accept", act_b1, 1);
      idle();
      step();
      chk("sb7_we_cycle", act_b1, 1);
      step();
      chk("sb7_after", act_b1, 0);

      // set/clear collision on x9
      s_rs1 = 5'd9;
      s_set = 1; s_set_rd = 5'd9;
      s_v0 = 1; s_rd0 = 5'd9; s_d0 = 32'h9999;
      step();
      idle();
      step();
      step();
      chk("sb9_collide", act_b1, 1);
      s_v0 = 1; s_rd0 = 5'd9; s_d0 = 32'h9A9A;
      step();
      idle();
      step();

      // reset mid-transfer; write to non-busy x3
      s_v0 = 1; s_rd0 = 5'd3; s_d0 = 32'h3333;
      step();
      s_reset = 1; s_rd0 = 5'd4; s_d0 = 32'h4444;
      step();
      chk("rst_unexp_x3", bus.unexp_wb, 1);
      chk("rst_r0_held", act_r0, 0);
      s_reset = 0;
      step();
      chk("rst_we_drop", bus.rf_we, 0);
      idle();
      step();

      // random traffic
      held0 = 0; held1 = 0;
      for (int n = 0; n < 2000; n++) begin
         rnd();
         step();
      end
      idle();
      held0 = 0; held1 = 0;
      repeat (3) step();

      @(posedge clk);
      #2;
      chk("queue_drain", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
